// File: rtl/imgproc_frame_ctrl.sv
// Frame-level sequencer for the grayscale -> row buffer -> 3x3 conv pipeline.
// Detects frame start and end on the raw pixel stream, latches a debounced kernel select, and drains the pipeline.
module imgproc_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int DEB_CYC  = 50000,
  parameter int PIPE_LAT = 4,
  parameter int TIMEOUT  = 1 << 20
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iSW,
  output logic        oMODE,
  output logic        oPIPE_EN,
  output logic        oFRAME_START,
  output logic        oFRAME_DONE,
  output logic        oFRAME_ABORT,
  output logic [15:0] oFRAME_CNT,
  output logic [1:0]  oDbgState,
  output logic        oDbgSwDb
);

  localparam int PIX_RAW = $clog2(IMG_W * IMG_H + 1);
  localparam int PIX_W   = (PIX_RAW > 17) ? PIX_RAW : 17;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int DR_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  localparam logic [PIX_W-1:0] FRAME_PIX = PIX_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state, stateNxt;

  logic              swMeta, swSync, swDb;
  logic [DEB_W-1:0]  debCnt;
  logic [PIX_W-1:0]  pixCnt, pixNxt;
  logic [IDLE_W-1:0] idleCnt, idleNxt;
  logic [DR_W-1:0]   drainCnt, drainNxt;
  logic              modeNxt, pipeNxt, startNxt, doneNxt, abortNxt;
  logic [15:0]       cntNxt;

  logic startPix, lastPix, countOk, idleExpired, drainEnd;

  // The pixel stream is valid-only: a pixel is consumed on every edge where
  // iDVAL=1, and there is no ready signal, so the pipeline can never stall it.
  assign startPix    = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign lastPix     = iDVAL && (iX_Cont == 16'(IMG_W - 1)) && (iY_Cont == 16'(IMG_H - 1));
  assign countOk     = (pixCnt + PIX_W'(1)) == FRAME_PIX;
  assign idleExpired = idleCnt == IDLE_W'(TIMEOUT - 1);
  assign drainEnd    = drainCnt == DR_W'(PIPE_LAT - 1);

  // Switch path: swDb only follows swSync after DEB_CYC samples that all differ from it.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      swMeta <= 1'b0;
      swSync <= 1'b0;
      swDb   <= 1'b0;
      debCnt <= '0;
    end else begin
      swMeta <= iSW;
      swSync <= swMeta;
      if (swSync == swDb) begin
        debCnt <= '0;
      end else if (debCnt == DEB_W'(DEB_CYC - 1)) begin
        swDb   <= swSync;
        debCnt <= '0;
      end else begin
        debCnt <= debCnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (startPix) stateNxt = ACTIVE;
      end
      ACTIVE: begin
        if (startPix)                   stateNxt = ACTIVE;
        else if (lastPix)               stateNxt = countOk ? DRAIN : IDLE;
        else if (!iDVAL && idleExpired) stateNxt = IDLE;
      end
      DRAIN: begin
        if (startPix)      stateNxt = ACTIVE;
        else if (drainEnd) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    startNxt = 1'b0;
    abortNxt = 1'b0;
    doneNxt  = 1'b0;
    modeNxt  = oMODE;
    pixNxt   = pixCnt;
    idleNxt  = idleCnt;
    drainNxt = drainCnt;
    cntNxt   = oFRAME_CNT;
    case (state)
      IDLE: begin
        if (startPix) begin
          startNxt = 1'b1;
          modeNxt  = swDb;
          pixNxt   = PIX_W'(1);
          idleNxt  = '0;
        end
      end
      ACTIVE: begin
        if (startPix) begin
          abortNxt = 1'b1;
          startNxt = 1'b1;
          modeNxt  = swDb;
          pixNxt   = PIX_W'(1);
          idleNxt  = '0;
        end else if (lastPix) begin
          if (countOk) drainNxt = '0;
          else         abortNxt = 1'b1;
        end else if (iDVAL) begin
          pixNxt  = (pixCnt == {PIX_W{1'b1}}) ? pixCnt : pixCnt + PIX_W'(1);
          idleNxt = '0;
        end else if (idleExpired) begin
          abortNxt = 1'b1;
        end else begin
          idleNxt = idleCnt + IDLE_W'(1);
        end
      end
      DRAIN: begin
        drainNxt = drainCnt + DR_W'(1);
        if (startPix) begin
          doneNxt  = 1'b1;
          startNxt = 1'b1;
          cntNxt   = oFRAME_CNT + 16'd1;
          modeNxt  = swDb;
          pixNxt   = PIX_W'(1);
          idleNxt  = '0;
        end else if (drainEnd) begin
          doneNxt = 1'b1;
          cntNxt  = oFRAME_CNT + 16'd1;
        end
      end
      default: ;
    endcase
    // Enable lingers one cycle past a completed drain so the final conv output is taken.
    pipeNxt = (stateNxt != IDLE) || doneNxt;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oMODE        <= 1'b0;
      oPIPE_EN     <= 1'b0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oFRAME_ABORT <= 1'b0;
      oFRAME_CNT   <= 16'd0;
      pixCnt       <= '0;
      idleCnt      <= '0;
      drainCnt     <= '0;
    end else begin
      oMODE        <= modeNxt;
      oPIPE_EN     <= pipeNxt;
      oFRAME_START <= startNxt;
      oFRAME_DONE  <= doneNxt;
      oFRAME_ABORT <= abortNxt;
      oFRAME_CNT   <= cntNxt;
      pixCnt       <= pixNxt;
      idleCnt      <= idleNxt;
      drainCnt     <= drainNxt;
    end
  end

  assign oDbgState = state;
  assign oDbgSwDb  = swDb;

endmodule

// File: tb/tb_imgproc_frame_ctrl.sv
// Directed bench for imgproc_frame_ctrl on a 4x3 frame with short debounce, latency and timeout.
module tb_imgproc_frame_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iDVAL = 1'b0;
  logic [15:0] iX_Cont = 16'd0;
  logic [15:0] iY_Cont = 16'd0;
  logic        iSW = 1'b0;
  logic        oMODE, oPIPE_EN, oFRAME_START, oFRAME_DONE, oFRAME_ABORT;
  logic [15:0] oFRAME_CNT;
  logic [1:0]  oDbgState;
  logic        oDbgSwDb;

  imgproc_frame_ctrl #(
    .IMG_W(4), .IMG_H(3), .DEB_CYC(8), .PIPE_LAT(4), .TIMEOUT(16)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iSW(iSW), .oMODE(oMODE), .oPIPE_EN(oPIPE_EN), .oFRAME_START(oFRAME_START),
    .oFRAME_DONE(oFRAME_DONE), .oFRAME_ABORT(oFRAME_ABORT), .oFRAME_CNT(oFRAME_CNT),
    .oDbgState(oDbgState), .oDbgSwDb(oDbgSwDb)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nStart, nDone, nAbort, nPipe, startCyc, doneCyc;
  int nBadMode = 0;
  int nSwLow;
  logic prevMode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    nStart = 0; nDone = 0; nAbort = 0; nPipe = 0; startCyc = -1; doneCyc = -1;
  endtask

  // One clock; outputs are sampled 1ns after the edge and tallied.
  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
    if (oFRAME_START) begin nStart++; startCyc = cyc; end
    if (oFRAME_DONE)  begin nDone++;  doneCyc  = cyc; end
    if (oFRAME_ABORT) nAbort++;
    if (oPIPE_EN)     nPipe++;
    if (oMODE !== prevMode && !oFRAME_START) nBadMode++;
    prevMode = oMODE;
  endtask

  task automatic pix(input logic v, input int x, input int y);
    iDVAL = v;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    step();
  endtask

  task automatic frame_px(input int from, input int to);
    for (int i = from; i <= to; i++) pix(1'b1, i % 4, i / 4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1, 1);
  endtask

  initial begin
    clr_stats();
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_state", 32'(oDbgState), 0);
    chk("rst_pipe", 32'(oPIPE_EN), 0);
    chk("rst_cnt", 32'(oFRAME_CNT), 0);
    chk("rst_mode", 32'(oMODE), 0);
    iRST = 1'b0;

    // Frame 1: clean 12-pixel frame
    cyc = 0;
    clr_stats();
    frame_px(0, 11);
    idle(8);
    chk("f1_start_cyc", 32'(startCyc), 1);
    chk("f1_done_cyc", 32'(doneCyc), 16);
    chk("f1_pipe_cycles", 32'(nPipe), 16);
    chk("f1_done_n", 32'(nDone), 1);
    chk("f1_abort_n", 32'(nAbort), 0);
    chk("f1_cnt", 32'(oFRAME_CNT), 1);
    chk("f1_state", 32'(oDbgState), 0);

    // Frame 2: switch moves mid-frame, mode waits for next start
    frame_px(0, 4);
    iSW = 1'b1;
    frame_px(5, 11);
    idle(12);
    chk("sw_db_after_hold", 32'(oDbgSwDb), 1);
    chk("mode_held", 32'(oMODE), 0);
    chk("f2_cnt", 32'(oFRAME_CNT), 2);
    frame_px(0, 0);
    chk("f3_start", 32'(oFRAME_START), 1);
    chk("f3_mode_at_start", 32'(oMODE), 1);
    frame_px(1, 11);
    idle(8);
    chk("f3_cnt", 32'(oFRAME_CNT), 3);

    // Bouncing switch with 3-cycle glitches never reaches the debounce threshold
    nSwLow = 0;
    for (int r = 0; r < 6; r++) begin
      iSW = 1'b0;
      for (int k = 0; k < 3; k++) begin idle(1); if (!oDbgSwDb) nSwLow++; end
      iSW = 1'b1;
      for (int k = 0; k < 3; k++) begin idle(1); if (!oDbgSwDb) nSwLow++; end
    end
    idle(4);
    chk("bounce_sw_db", 32'(nSwLow), 0);
    chk("bounce_mode", 32'(oMODE), 1);

    // Dropped pixel: last pixel arrives with a short count
    clr_stats();
    frame_px(0, 5);
    idle(1);
    frame_px(7, 11);
    idle(6);
    chk("drop_abort_n", 32'(nAbort), 1);
    chk("drop_done_n", 32'(nDone), 0);
    chk("drop_cnt", 32'(oFRAME_CNT), 3);
    chk("drop_state", 32'(oDbgState), 0);
    chk("drop_pipe", 32'(oPIPE_EN), 0);

    // Restart mid-frame
    clr_stats();
    frame_px(0, 4);
    pix(1'b1, 0, 0);
    chk("restart_abort", 32'(oFRAME_ABORT), 1);
    chk("restart_start", 32'(oFRAME_START), 1);
    frame_px(1, 11);
    idle(8);
    chk("restart_done_n", 32'(nDone), 1);
    chk("restart_cnt", 32'(oFRAME_CNT), 4);

    // Stall timeout
    clr_stats();
    frame_px(0, 2);
    idle(15);
    chk("pre_to_abort", 32'(oFRAME_ABORT), 0);
    chk("pre_to_pipe", 32'(oPIPE_EN), 1);
    idle(1);
    chk("to_abort", 32'(oFRAME_ABORT), 1);
    chk("to_pipe", 32'(oPIPE_EN), 0);
    chk("to_state", 32'(oDbgState), 0);
    chk("to_cnt", 32'(oFRAME_CNT), 4);

    // Non-start pixels in IDLE, including the last pixel, are ignored
    clr_stats();
    pix(1'b1, 2, 1);
    pix(1'b1, 3, 2);
    idle(2);
    chk("ign_pipe_cycles", 32'(nPipe), 0);
    chk("ign_start_n", 32'(nStart), 0);
    chk("ign_abort_n", 32'(nAbort), 0);
    chk("ign_state", 32'(oDbgState), 0);

    // Start pixel while draining
    clr_stats();
    frame_px(0, 11);
    idle(1);
    pix(1'b1, 0, 0);
    chk("drst_done", 32'(oFRAME_DONE), 1);
    chk("drst_start", 32'(oFRAME_START), 1);
    chk("drst_cnt", 32'(oFRAME_CNT), 5);
    chk("drst_state", 32'(oDbgState), 1);
    frame_px(1, 11);
    idle(8);
    chk("drst_done_n", 32'(nDone), 2);
    chk("drst_cnt_end", 32'(oFRAME_CNT), 6);

    // Reset in the middle of DRAIN
    clr_stats();
    frame_px(0, 11);
    idle(2);
    chk("pre_rst_state", 32'(oDbgState), 2);
    iRST = 1'b1;
    prevMode = 1'b0;
    #1;
    chk("mid_rst_pipe", 32'(oPIPE_EN), 0);
    chk("mid_rst_cnt", 32'(oFRAME_CNT), 0);
    chk("mid_rst_state", 32'(oDbgState), 0);
    chk("mid_rst_done", 32'(oFRAME_DONE), 0);
    chk("mid_rst_mode", 32'(oMODE), 0);
    idle(2);
    iRST = 1'b0;
    idle(6);
    chk("post_rst_done_n", 32'(nDone), 0);
    chk("post_rst_cnt", 32'(oFRAME_CNT), 0);

    chk("mode_only_at_start", 32'(nBadMode), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
